// File: rtl/mux_scan_pkg.sv
// Shared constants and state type for the mux select scanner.
package mux_scan_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first requesting channel after ptr, wrapping back to ptr last.
module rr_pick4
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx  = ptr;
        cand = '0;
        any  = |req;
        for (int k = N_CH; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_select_scanner.sv
// Round-robin scanner driving the select of a 4:1 mux with a programmable dwell.
module mux_select_scanner
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_CH-1:0]    req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               hold,
    output logic [SEL_W-1:0]   select,
    output logic               sel_valid,
    output logic               sample
);

    state_t             state_q, state_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [SEL_W-1:0]   last_q, last_n;
    logic [SEL_W-1:0]   select_n;
    logic               valid_n;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               regrant;
    logic [DWELL_W-1:0] dwell_ld;

    // In GRANT last equals select, so one picker serves both entry and re-pick.
    rr_pick4 u_pick (
        .req (req),
        .ptr (last_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A dwell of zero behaves like a single-cycle grant.
    assign dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Next-state, counter, select and sample strobe decode.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        last_n   = last_q;
        select_n = select;
        valid_n  = sel_valid;
        sample   = 1'b0;
        regrant  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_n = 1'b0;
                if (enable && pick_any) begin
                    regrant = 1'b1;
                end
            end
            GRANT: begin
                if (!enable) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else if (!req[select]) begin
                    // Owner withdrew early: abort without a strobe.
                    if (pick_any) begin
                        regrant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end else if (!hold) begin
                    if (cnt_q > DWELL_W'(1)) begin
                        cnt_n = cnt_q - DWELL_W'(1);
                    end else begin
                        sample  = 1'b1;
                        regrant = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase

        if (regrant) begin
            state_n  = GRANT;
            select_n = pick_idx;
            last_n   = pick_idx;
            cnt_n    = dwell_ld;
            valid_n  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SEL_W'(3);
            select    <= '0;
            sel_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            last_q    <= last_n;
            select    <= select_n;
            sel_valid <= valid_n;
        end
    end

endmodule
